// File: rtl/gun_light_sampler.sv
// Light-gun photodiode sampler: on each VAUX4 end-of-conversion, reads the XADC
// result over DRP, averages 2^AVG_LOG2 reads and derives a hysteresis light flag.
module gun_light_sampler #(
  parameter logic [4:0]  CHANNEL   = 5'h14,
  parameter logic [6:0]  DRP_ADDR  = 7'h14,
  parameter int          AVG_LOG2  = 2,
  parameter logic [11:0] THRESH_HI = 12'd2400,
  parameter logic [11:0] THRESH_LO = 12'd2000,
  parameter logic [7:0]  TIMEOUT   = 8'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  output logic [11:0] sample_out,
  output logic        sample_valid,
  output logic        light_on,
  output logic        drp_timeout,
  output logic        overrun
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_e;

  state_e             state_q, state_d;
  logic [7:0]         timer_q, timer_d;
  logic [11:0]        cap_q, cap_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic               den_q, den_d;
  logic               valid_q, valid_d;
  logic [11:0]        sample_q, sample_d;
  logic               light_q, light_d;
  logic               tmo_q, tmo_d;
  logic               ovr_q, ovr_d;

  logic               eoc_match;
  logic               timer_last;
  logic [ACC_W-1:0]   sum;
  logic               unused_lsbs;

  // Averaging by truncation: the top 12 bits of the sum are sum >> AVG_LOG2.
  function automatic logic [11:0] avg_of(input logic [ACC_W-1:0] s);
    return s[ACC_W-1 -: 12];
  endfunction

  function automatic logic hyst(input logic [11:0] s, input logic cur);
    if (s >= THRESH_HI) return 1'b1;
    if (s <= THRESH_LO) return 1'b0;
    return cur;
  endfunction

  assign eoc_match   = eoc_in && (channel_in == CHANNEL);
  assign timer_last  = (timer_q + 8'd1) == (TIMEOUT - 8'd1);
  assign sum         = acc_q + ACC_W'(cap_q);
  assign unused_lsbs = ^do_in[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && eoc_match) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (drdy_in) state_d = ACC;
               else if (timer_last) state_d = IDLE;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    den_d    = 1'b0;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
    ovr_d    = eoc_match && (state_q != IDLE);
    timer_d  = timer_q;
    cap_d    = cap_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    light_d  = light_q;
    // A read that saw enable low at any point is discarded along with the partial set.
    abort_d  = abort_q || (!enable && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (!enable) begin
          acc_d = '0;
          cnt_d = '0;
        end
        if (enable && eoc_match) begin
          den_d   = 1'b1;
          abort_d = 1'b0;
        end
      end
      REQ: timer_d = '0;
      WAIT: begin
        timer_d = timer_q + 8'd1;
        if (drdy_in) begin
          cap_d = do_in[15:4];
        end else if (timer_last) begin
          tmo_d = 1'b1;
          if (abort_d) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
      ACC: begin
        if (abort_d) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          sample_d = avg_of(sum);
          light_d  = hyst(avg_of(sum), light_q);
          valid_d  = 1'b1;
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      cap_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      den_q    <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
      light_q  <= 1'b0;
      tmo_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      cap_q    <= cap_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      den_q    <= den_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      light_q  <= light_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
    end
  end

  assign daddr_out    = DRP_ADDR;
  assign dwe_out      = 1'b0;
  assign di_out       = 16'h0000;
  assign den_out      = den_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign light_on     = light_q;
  assign drp_timeout  = tmo_q;
  assign overrun      = ovr_q;

endmodule
